display_hex: RTL



---
 rtl/display_pkg.sv | 43 ++++
 rtl/lcd_write_strobe.sv | 126 ++++++++++++
 rtl/display_hex.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  display_pkg
//  Shared state encoding, LCD command bytes and nibble-to-ASCII helper.
//  Revision: 1.0
// ============================================================================
package display_pkg;

   // Strobe phase encoding
   typedef logic [2:0] phase_t;

   localparam phase_t PH_IDLE  = 3'd0;
   localparam phase_t PH_SETUP = 3'd1;
   localparam phase_t PH_PULSE = 3'd2;
   localparam phase_t PH_HOLD  = 3'd3;
   localparam phase_t PH_WAIT  = 3'd4;

   // HD44780 command bytes
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_FUNC    = 8'h38;
   localparam logic [7:0] CMD_DISP_ON = 8'h0C;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
      if (nibble < 4'd10)
         return 8'h30 + {4'h0, nibble};
      else
         return 8'h37 + {4'h0, nibble};
   endfunction

   function automatic int max_cycles(input int a, input int b, input int c,
                                     input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_write_strobe.sv
`default_nettype none
// ============================================================================
//  lcd_write_strobe
//  One LCD bus write: setup, enable pulse, hold, then busy-wait, counted down.
//  Revision: 1.0
// ============================================================================
module lcd_write_strobe #(
   parameter int SETUP   = 2,
   parameter int E_PULSE = 12,
   parameter int HOLD    = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_go,
   input  logic             i_rs,
   input  logic [7:0]       i_data,
   input  logic [CNT_W-1:0] i_wait_cycles,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_lcd_e,
   output logic             o_lcd_rs,
   output logic [7:0]       o_lcd_data
);
   import display_pkg::*;

   localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(SETUP - 1);
   localparam logic [CNT_W-1:0] c_pulse_ld = CNT_W'(E_PULSE - 1);
   localparam logic [CNT_W-1:0] c_hold_ld  = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   phase_t           r_phase;
   phase_t           w_phase_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_wait;
   logic             r_lcd_e;
   logic             r_lcd_rs;
   logic [7:0]       r_lcd_data;
   logic             w_cnt_zero;
   logic             w_last;
   logic             w_accept;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_last     = (r_phase == PH_WAIT) && w_cnt_zero;
   // A new write may start on the final wait cycle so back-to-back writes have no idle gap
   assign o_ready    = (r_phase == PH_IDLE) || w_last;
   assign w_accept   = i_go && o_ready;
   assign o_busy     = (r_phase != PH_IDLE);

   always_comb begin
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt;
      if (w_accept) begin
         w_phase_nxt = PH_SETUP;
         w_cnt_nxt   = c_setup_ld;
      end else begin
         case (r_phase)
            PH_IDLE: begin
               w_cnt_nxt = '0;
            end
            PH_SETUP: begin
               if (w_cnt_zero) begin
                  w_phase_nxt = PH_PULSE;
                  w_cnt_nxt   = c_pulse_ld;
               end else begin
                  w_cnt_nxt = r_cnt - c_one;
               end
            end
            PH_PULSE: begin
               if (w_cnt_zero) begin
                  w_phase_nxt = PH_HOLD;
                  w_cnt_nxt   = c_hold_ld;
               end else begin
                  w_cnt_nxt = r_cnt - c_one;
               end
            end
            PH_HOLD: begin
               if (w_cnt_zero) begin
                  w_phase_nxt = PH_WAIT;
                  w_cnt_nxt   = r_wait - c_one;
               end else begin
                  w_cnt_nxt = r_cnt - c_one;
               end
            end
            PH_WAIT: begin
               if (w_cnt_zero) begin
                  w_phase_nxt = PH_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - c_one;
               end
            end
            default: begin
               w_phase_nxt = PH_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase    <= PH_IDLE;
         r_cnt      <= '0;
         r_wait     <= '0;
         r_lcd_e    <= 1'b0;
         r_lcd_rs   <= 1'b0;
         r_lcd_data <= 8'h00;
      end else begin
         r_phase <= w_phase_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lcd_e <= (w_phase_nxt == PH_PULSE);
         if (w_accept) begin
            r_lcd_rs   <= i_rs;
            r_lcd_data <= i_data;
            r_wait     <= i_wait_cycles;
         end
      end
   end

   assign o_lcd_e    = r_lcd_e;
   assign o_lcd_rs   = r_lcd_rs;
   assign o_lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: rtl/display_hex.sv
`default_nettype none
// ============================================================================
//  display_hex
//  Writes one hex nibble as ASCII (or a clear command) to an HD44780 LCD.
//  Optional power-up init sequence: define LCD_INIT_EN.
//  Revision: 1.0
// ============================================================================
module display_hex #(
   parameter int SETUP      = 2,
   parameter int E_PULSE    = 12,
   parameter int HOLD       = 2,
   parameter int CHAR_WAIT  = 1000,
   parameter int CLEAR_WAIT = 41000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] display_hex_data_in,
   input  logic       display_hex_start,
   input  logic       clearAll,
   output logic       display_hex_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e
);
   import display_pkg::*;

   localparam int c_max_cycles = max_cycles(SETUP, E_PULSE, HOLD, CHAR_WAIT, CLEAR_WAIT);
   localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

   localparam logic [c_cnt_w-1:0] c_char_wait  = c_cnt_w'(CHAR_WAIT);
   localparam logic [c_cnt_w-1:0] c_clear_wait = c_cnt_w'(CLEAR_WAIT);

   logic               w_go;
   logic               w_rs;
   logic [7:0]         w_data;
   logic [c_cnt_w-1:0] w_wait;
   logic               w_ready;
   logic               w_busy;
   logic               w_set_pend;
   logic               w_take_pend;
   logic               r_pending;
   logic [3:0]         r_pend_nibble;
   logic               w_init_active;
   logic               w_init_last;
   logic [7:0]         w_init_cmd;

`ifdef LCD_INIT_EN
   logic       r_init_active;
   logic [1:0] r_init_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_init_active <= 1'b1;
         r_init_idx    <= 2'd0;
      end else if (r_init_active && w_go) begin
         r_init_idx <= r_init_idx + 2'd1;
         if (r_init_idx == 2'd3)
            r_init_active <= 1'b0;
      end
   end

   assign w_init_active = r_init_active;
   assign w_init_last   = (r_init_idx == 2'd3);

   always_comb begin
      w_init_cmd = CMD_FUNC;
      case (r_init_idx)
         2'd0:    w_init_cmd = CMD_FUNC;
         2'd1:    w_init_cmd = CMD_DISP_ON;
         2'd2:    w_init_cmd = CMD_ENTRY;
         default: w_init_cmd = CMD_CLEAR;
      endcase
   end
`else
   assign w_init_active = 1'b0;
   assign w_init_last   = 1'b0;
   assign w_init_cmd    = 8'h00;
`endif

   // Priority: init ROM, then a character queued behind a clear, then new requests
   always_comb begin
      w_go        = 1'b0;
      w_rs        = 1'b0;
      w_data      = 8'h00;
      w_wait      = c_char_wait;
      w_set_pend  = 1'b0;
      w_take_pend = 1'b0;
      if (w_init_active) begin
         if (w_ready) begin
            w_go   = 1'b1;
            w_data = w_init_cmd;
            w_wait = w_init_last ? c_clear_wait : c_char_wait;
         end
      end else if (r_pending) begin
         if (w_ready) begin
            w_go        = 1'b1;
            w_rs        = 1'b1;
            w_data      = nibble_to_ascii(r_pend_nibble);
            w_take_pend = 1'b1;
         end
      end else if (!w_busy) begin
         if (clearAll) begin
            w_go       = 1'b1;
            w_data     = CMD_CLEAR;
            w_wait     = c_clear_wait;
            w_set_pend = display_hex_start;
         end else if (display_hex_start) begin
            w_go   = 1'b1;
            w_rs   = 1'b1;
            w_data = nibble_to_ascii(display_hex_data_in);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pending     <= 1'b0;
         r_pend_nibble <= 4'h0;
      end else if (w_set_pend) begin
         r_pending     <= 1'b1;
         r_pend_nibble <= display_hex_data_in;
      end else if (w_take_pend) begin
         r_pending <= 1'b0;
      end
   end

   lcd_write_strobe #(
      .SETUP   (SETUP),
      .E_PULSE (E_PULSE),
      .HOLD    (HOLD),
      .CNT_W   (c_cnt_w)
   ) u_strobe (
      .clock         (clock),
      .reset         (reset),
      .i_go          (w_go),
      .i_rs          (w_rs),
      .i_data        (w_data),
      .i_wait_cycles (w_wait),
      .o_ready       (w_ready),
      .o_busy        (w_busy),
      .o_lcd_e       (lcd_e),
      .o_lcd_rs      (lcd_rs),
      .o_lcd_data    (lcd_data)
   );

   assign display_hex_done = ~w_busy & ~w_init_active;
   assign lcd_rw           = 1'b0;

endmodule
`default_nettype wire
